high_counter: RTL and testbench

- Free-running rising-edge counter for clock measurement.
- Counts every rising edge of clk since the last reset release and presents the running total on count.
- Used by the PLL/clock test infrastructure to measure clock frequency: count over a known time window equals window/period.
- Purely synchronous counting, with an asynchronous active-low clear.

---
 rtl/high_counter.sv | 50 +++++
 tb/tb_high_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/high_counter.sv
// Free-running rising-edge counter with sticky terminal flag.
// Build option HIGH_COUNTER_SATURATE_EN: hold at terminal instead of wrapping.
`timescale 1ns/1ps
module high_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] TERM = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_inc;
  logic             overflow_q;
  logic             overflow_d;

  // next count and sticky flag on reaching the terminal value
  always_comb begin
    count_inc  = count_q + WIDTH'(1);
    count_d    = count_inc;
    overflow_d = overflow_q;
`ifdef HIGH_COUNTER_SATURATE_EN
    if (count_q == TERM) begin
      count_d = count_q;
    end
`endif
    if (count_d == TERM) begin
      overflow_d = 1'b1;
    end
  end

  // count every rising edge; active-low rst clears at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_high_counter.sv
// Scoreboard bench for high_counter: a 32-bit and a 4-bit instance.
// Expectations follow HIGH_COUNTER_SATURATE_EN if it is defined.
`timescale 1ns/1ps
module tb_high_counter;

  logic        clk_a;
  logic        rst_a;
  logic [31:0] count_a;
  logic        ovf_a;

  logic        clk_b;
  logic        rst_b;
  logic [3:0]  count_b;
  logic        ovf_b;

  high_counter #(.WIDTH(32)) u_a (
    .clk      (clk_a),
    .rst      (rst_a),
    .count    (count_a),
    .overflow (ovf_a)
  );

  high_counter #(.WIDTH(4)) u_b (
    .clk      (clk_b),
    .rst      (rst_b),
    .count    (count_b),
    .overflow (ovf_b)
  );

  typedef struct {
    string       name;
    bit          sel_b;
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  event ev_sample;
  int   n_chk  = 0;
  int   n_pass = 0;

  // monitor: compare all pending expectations when a sample point is flagged
  initial begin
    forever begin
      @(ev_sample);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] c;
        logic        o;
        e = q.pop_front();
        c = e.sel_b ? {28'd0, count_b} : count_a;
        o = e.sel_b ? ovf_b : ovf_a;
        n_chk++;
        if (c === e.cnt && o === e.ovf) begin
          n_pass++;
        end else begin
          $display("FAIL %s: count=%0d overflow=%b, expected count=%0d overflow=%b",
                   e.name, c, o, e.cnt, e.ovf);
        end
      end
    end
  end

  task automatic expect_now(input string name, input bit sel_b,
                            input logic [31:0] cnt, input logic ovf);
    exp_t e;
    e.name  = name;
    e.sel_b = sel_b;
    e.cnt   = cnt;
    e.ovf   = ovf;
    q.push_back(e);
    ->ev_sample;
    #1;
  endtask

  task automatic tick_a(input int n, input int half);
    repeat (n) begin
      clk_a = 1'b1;
      #(half);
      clk_a = 1'b0;
      #(half);
    end
  endtask

  task automatic tick_b(input int n);
    repeat (n) begin
      clk_b = 1'b1;
      #5;
      clk_b = 1'b0;
      #5;
    end
  endtask

  logic [31:0] e_wrap16;
  logic [31:0] e_wrap17;
  logic [31:0] e_wrap20;

  initial begin
`ifdef HIGH_COUNTER_SATURATE_EN
    e_wrap16 = 32'd15;
    e_wrap17 = 32'd15;
    e_wrap20 = 32'd15;
`else
    e_wrap16 = 32'd0;
    e_wrap17 = 32'd1;
    e_wrap20 = 32'd4;
`endif
    clk_a = 1'b0;
    rst_a = 1'b0;
    clk_b = 1'b0;
    rst_b = 1'b0;
    #3;
    expect_now("reset_state_a", 1'b0, 32'd0, 1'b0);
    expect_now("reset_state_b", 1'b1, 32'd0, 1'b0);
    tick_a(3, 5);
    expect_now("edges_in_reset", 1'b0, 32'd0, 1'b0);

    // basic count: 100 edges at 10 ns
    rst_a = 1'b1;
    #1;
    tick_a(100, 5);
    expect_now("basic_count_100", 1'b0, 32'd100, 1'b0);

    // async clear without a clock edge
    tick_a(3, 5);
    expect_now("count_103", 1'b0, 32'd103, 1'b0);
    #2;
    rst_a = 1'b0;
    #0.001;
    expect_now("async_clear", 1'b0, 32'd0, 1'b0);

    // clock change: 10 edges at 100 ns
    #10;
    rst_a = 1'b1;
    #1;
    tick_a(10, 50);
    expect_now("clock_change_10", 1'b0, 32'd10, 1'b0);

    // mixed periods then stopped clock
    rst_a = 1'b0;
    #10;
    rst_a = 1'b1;
    #1;
    tick_a(2, 5);
    tick_a(5, 50);
    expect_now("mixed_period_7", 1'b0, 32'd7, 1'b0);
    #500;
    expect_now("clock_stopped", 1'b0, 32'd7, 1'b0);
    clk_a = 1'b1;
    #1;
    expect_now("rising_edge_8", 1'b0, 32'd8, 1'b0);
    clk_a = 1'b0;
    #1;
    expect_now("falling_no_effect", 1'b0, 32'd8, 1'b0);

    // 4-bit terminal behaviour
    rst_b = 1'b1;
    #1;
    tick_b(14);
    expect_now("w4_edge14", 1'b1, 32'd14, 1'b0);
    tick_b(1);
    expect_now("w4_edge15_term", 1'b1, 32'd15, 1'b1);
    tick_b(1);
    expect_now("w4_edge16", 1'b1, e_wrap16, 1'b1);
    tick_b(1);
    expect_now("w4_edge17", 1'b1, e_wrap17, 1'b1);
    tick_b(3);
    expect_now("w4_edge20", 1'b1, e_wrap20, 1'b1);
    #2;
    rst_b = 1'b0;
    #0.001;
    expect_now("w4_reset_clear", 1'b1, 32'd0, 1'b0);
    tick_b(2);
    expect_now("w4_held_in_reset", 1'b1, 32'd0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) #1;
    if (q.size() > 0) begin
      n_chk += q.size();
      $display("FAIL scoreboard_drain: pending=%0d, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
